// File: rtl/bcp_pkg.sv
// Shared BCP types: literals, clause-queue nodes and per-literal header entries.
`ifndef BCP_PKG_DEFINES
`define BCP_PKG_DEFINES
`define NUM_ENGINE   2
`define TOTAL_CLAUSE (`NUM_ENGINE * 16)
`define LIT_IDX_MAX  200
`define CLQ_DEPTH    (`TOTAL_CLAUSE * 3)
`endif

package bcp_pkg;

    localparam int LIT_W = $clog2(`LIT_IDX_MAX + 1);
    localparam int CLA_W = $clog2(`TOTAL_CLAUSE);
    localparam int PTR_W = $clog2(`CLQ_DEPTH + 1);

    typedef logic [LIT_W-1:0] lit_t;

    typedef struct packed {
        logic [CLA_W-1:0] cla;
        logic [PTR_W-1:0] ptr;
    } node_t;

    typedef struct packed {
        logic [PTR_W-1:0] ptr;
    } dummy_entry_t;

endpackage

// File: rtl/ld_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
module ld_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/clq_stream_loader.sv
// Streams the preloaded CNF image (nodes, then headers) into top, one engine at a time,
// holding halt until every engine has been loaded.
module clq_stream_loader
    import bcp_pkg::*;
#(
    parameter int NUM_ENGINE        = `NUM_ENGINE,
    parameter int CLAUSE_PER_ENGINE = 16,
    parameter int LIT_PER_CLAUSE    = 3,
    parameter int NUM_VAR           = 100,
    localparam int NPE    = CLAUSE_PER_ENGINE * LIT_PER_CLAUSE,
    localparam int HPE    = 2 * NUM_VAR,
    localparam int ADDR_W = $clog2(NUM_ENGINE * ((NPE > HPE) ? NPE : HPE))
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  node_t             wr_node,
    input  dummy_entry_t      wr_hdr,
    input  logic              start,
    input  logic              out_ready,
    output node_t             node_in,
    output logic              node_in_valid,
    output dummy_entry_t      dummy_ptr,
    output logic              dummy_ptr_valid,
    output logic              change_eng,
    output logic              halt,
    output logic              done
);

    localparam int IDX_W = $clog2(((NPE > HPE) ? NPE : HPE) + 1);
    localparam int ENG_W = $clog2(NUM_ENGINE + 1);

    typedef enum logic [2:0] {IDLE, RD_NODE, NODE, RD_HDR, HDR, SWITCH, FIN} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [ENG_W-1:0]  eng, eng_nxt;
    logic [ADDR_W-1:0] node_base, node_base_nxt, hdr_base, hdr_base_nxt;

    logic              node_we, hdr_we, node_re, hdr_re;
    logic [ADDR_W-1:0] node_raddr, hdr_raddr;
    logic [$bits(node_t)-1:0]        node_q;
    logic [$bits(dummy_entry_t)-1:0] hdr_q;

    // The RAMs only accept preload writes while idle, so the image cannot change under a stream.
    assign node_we = (state == IDLE) && wr_en && !wr_sel;
    assign hdr_we  = (state == IDLE) && wr_en &&  wr_sel;

    ld_ram #(.DATA_W($bits(node_t)), .ADDR_W(ADDR_W)) u_node_ram (
        .clk   (clk),
        .we    (node_we),
        .waddr (wr_addr),
        .wdata (wr_node),
        .re    (node_re),
        .raddr (node_raddr),
        .rdata (node_q)
    );

    ld_ram #(.DATA_W($bits(dummy_entry_t)), .ADDR_W(ADDR_W)) u_hdr_ram (
        .clk   (clk),
        .we    (hdr_we),
        .waddr (wr_addr),
        .wdata (wr_hdr),
        .re    (hdr_re),
        .raddr (hdr_raddr),
        .rdata (hdr_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            eng       <= '0;
            node_base <= '0;
            hdr_base  <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            eng       <= eng_nxt;
            node_base <= node_base_nxt;
            hdr_base  <= hdr_base_nxt;
        end
    end

    // On an accepted non-final beat the next entry is read in the same cycle, so the
    // stream keeps one beat per cycle and the RAM output stays frozen while stalled.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        eng_nxt       = eng;
        node_base_nxt = node_base;
        hdr_base_nxt  = hdr_base;
        node_re       = 1'b0;
        hdr_re        = 1'b0;
        node_raddr    = node_base + ADDR_W'(idx);
        hdr_raddr     = hdr_base + ADDR_W'(idx);
        change_eng    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    idx_nxt       = '0;
                    eng_nxt       = '0;
                    node_base_nxt = '0;
                    hdr_base_nxt  = '0;
                    state_nxt     = RD_NODE;
                end
            end
            RD_NODE: begin
                node_re   = 1'b1;
                state_nxt = NODE;
            end
            NODE: begin
                if (out_ready) begin
                    if (idx == IDX_W'(NPE - 1)) begin
                        idx_nxt   = '0;
                        state_nxt = RD_HDR;
                    end else begin
                        idx_nxt    = idx + IDX_W'(1);
                        node_re    = 1'b1;
                        node_raddr = node_base + ADDR_W'(idx) + ADDR_W'(1);
                    end
                end
            end
            RD_HDR: begin
                hdr_re    = 1'b1;
                state_nxt = HDR;
            end
            HDR: begin
                if (out_ready) begin
                    if (idx == IDX_W'(HPE - 1)) begin
                        idx_nxt   = '0;
                        state_nxt = SWITCH;
                    end else begin
                        idx_nxt   = idx + IDX_W'(1);
                        hdr_re    = 1'b1;
                        hdr_raddr = hdr_base + ADDR_W'(idx) + ADDR_W'(1);
                    end
                end
            end
            SWITCH: begin
                change_eng = 1'b1;
                if (eng == ENG_W'(NUM_ENGINE - 1)) begin
                    state_nxt = FIN;
                end else begin
                    eng_nxt       = eng + ENG_W'(1);
                    node_base_nxt = node_base + ADDR_W'(NPE);
                    hdr_base_nxt  = hdr_base + ADDR_W'(HPE);
                    state_nxt     = RD_NODE;
                end
            end
            FIN:     state_nxt = FIN;
            default: state_nxt = IDLE;
        endcase
    end

    assign node_in_valid   = (state == NODE);
    assign dummy_ptr_valid = (state == HDR);
    assign node_in         = node_in_valid ? node_t'(node_q) : '0;
    assign dummy_ptr       = dummy_ptr_valid ? dummy_entry_t'(hdr_q) : '0;
    assign done            = (state == FIN);
    assign halt            = (state != FIN);

endmodule

// File: tb/tb_clq_stream_loader.sv
// Directed bench for clq_stream_loader: expected beat stream built from the preload rule
// and checked every cycle, plus literal checks on reset, latency, stalls and restart.
module tb_clq_stream_loader;
    import bcp_pkg::*;

    localparam int NE  = 2;
    localparam int NPE = 6;
    localparam int HPE = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_en, wr_sel, start, out_ready;
    logic [3:0]   wr_addr;
    node_t        wr_node;
    dummy_entry_t wr_hdr;
    node_t        node_in;
    dummy_entry_t dummy_ptr;
    logic         node_in_valid, dummy_ptr_valid, change_eng, halt, done;

    clq_stream_loader #(
        .NUM_ENGINE(2), .CLAUSE_PER_ENGINE(2), .LIT_PER_CLAUSE(3), .NUM_VAR(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_node(wr_node), .wr_hdr(wr_hdr), .start(start), .out_ready(out_ready),
        .node_in(node_in), .node_in_valid(node_in_valid), .dummy_ptr(dummy_ptr),
        .dummy_ptr_valid(dummy_ptr_valid), .change_eng(change_eng), .halt(halt), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct packed {
        logic [1:0]  kind;   // 0 node, 1 header, 2 engine change
        logic [15:0] data;
    } ev_t;

    ev_t  q[$];
    logic mon_en = 1'b0;
    logic exp_done = 1'b0;
    int   chg_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic node_t mk_node(input int a);
        node_t n;
        n.cla = CLA_W'(a);
        n.ptr = PTR_W'(a + 1);
        return n;
    endfunction

    function automatic dummy_entry_t mk_hdr(input int a);
        dummy_entry_t h;
        h.ptr = PTR_W'(8'h10 + a);
        return h;
    endfunction

    task automatic build_model();
        ev_t e;
        q.delete();
        for (int en = 0; en < NE; en++) begin
            for (int n = 0; n < NPE; n++) begin
                e.kind = 2'd0; e.data = 16'(mk_node(en * NPE + n)); q.push_back(e);
            end
            for (int h = 0; h < HPE; h++) begin
                e.kind = 2'd1; e.data = 16'(mk_hdr(en * HPE + h)); q.push_back(e);
            end
            e.kind = 2'd2; e.data = 16'd0; q.push_back(e);
        end
        exp_done = 1'b0;
        chg_cnt  = 0;
    endtask

    always @(negedge clk) begin
        chk("valid_mutex", 32'(node_in_valid & dummy_ptr_valid), 32'd0);
        if (mon_en) begin
            chk("done", 32'(done), 32'(exp_done));
            chk("halt", 32'(halt), 32'(!exp_done));
            if (node_in_valid) begin
                if (q.size() == 0) chk("node_valid_unexpected", 32'(node_in_valid), 32'd0);
                else begin
                    chk("node_kind", 32'(q[0].kind), 32'd0);
                    chk("node_data", 32'(node_in), 32'(q[0].data));
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (dummy_ptr_valid) begin
                if (q.size() == 0) chk("hdr_valid_unexpected", 32'(dummy_ptr_valid), 32'd0);
                else begin
                    chk("hdr_kind", 32'(q[0].kind), 32'd1);
                    chk("hdr_data", 32'(dummy_ptr), 32'(q[0].data));
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (change_eng) begin
                chg_cnt++;
                chk("change_no_valid", 32'(node_in_valid | dummy_ptr_valid), 32'd0);
                if (q.size() == 0) chk("change_unexpected", 32'(change_eng), 32'd0);
                else begin
                    chk("change_kind", 32'(q[0].kind), 32'd2);
                    void'(q.pop_front());
                    if (q.size() == 0) exp_done = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_halt"}, 32'(halt), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_node_valid"}, 32'(node_in_valid), 32'd0);
        chk({tag, "_hdr_valid"}, 32'(dummy_ptr_valid), 32'd0);
        chk({tag, "_change"}, 32'(change_eng), 32'd0);
        chk({tag, "_node_in"}, 32'(node_in), 32'd0);
        chk({tag, "_dummy_ptr"}, 32'(dummy_ptr), 32'd0);
    endtask

    logic [7:0] pat;
    int t0;

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0;
        wr_node = '0; wr_hdr = '0; start = 1'b0; out_ready = 1'b0;
        pat = 8'b1011_0110;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk_idle_outputs("reset");

        // Preload; the final header write coincides with start.
        for (int a = 0; a < NE * NPE; a++) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'(a); wr_node = mk_node(a);
            tick();
        end
        for (int a = 0; a < NE * HPE; a++) begin
            wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'(a); wr_hdr = mk_hdr(a);
            if (a == NE * HPE - 1) begin
                build_model();
                mon_en = 1'b1; out_ready = 1'b1; start = 1'b1; t0 = cyc_cnt;
            end
            tick();
        end
        wr_en = 1'b0; start = 1'b0;
        chk("latency_c1_no_valid", 32'(node_in_valid), 32'd0);
        tick();
        chk("latency_c2_valid", 32'(node_in_valid), 32'd1);
        chk("first_node", 32'(node_in), 32'(mk_node(0)));

        // Backpressure on node 3, with ignored start/write pulses during the stall.
        for (int i = 0; i < 20; i++) begin
            if (node_in_valid && node_in.cla == CLA_W'(3)) break;
            tick();
        end
        chk("reached_node3", 32'(node_in), 32'(mk_node(3)));
        out_ready = 1'b0;
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd8; wr_node = '1;
        tick();
        wr_sel = 1'b1; wr_addr = 4'd5; wr_hdr = '1;
        tick();
        start = 1'b0; wr_en = 1'b0;
        tick();
        tick();
        chk("stall_valid_held", 32'(node_in_valid), 32'd1);
        chk("stall_node_held", 32'(node_in), 32'(mk_node(3)));
        out_ready = 1'b1;

        for (int i = 0; i < 100 && !done; i++) tick();
        chk("run1_done", 32'(done), 32'd1);
        chk("run1_cycle_budget", 32'((cyc_cnt - t0) <= 31), 32'd1);
        tick();
        tick();
        chk("run1_done_sticky", 32'(done), 32'd1);
        chk("run1_halt_low", 32'(halt), 32'd0);
        chk("run1_change_count", 32'(chg_cnt), 32'd2);
        chk("run1_stream_drained", 32'(q.size()), 32'd0);

        // Second run, throttled, interrupted by reset in engine 1 headers.
        mon_en = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk_idle_outputs("rerun_idle");
        build_model();
        mon_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            out_ready = pat[i % 8];
            if (dummy_ptr_valid && dummy_ptr == mk_hdr(5)) break;
            tick();
        end
        chk("mid_hdr5_reached", 32'(dummy_ptr), 32'(mk_hdr(5)));
        chk("mid_change_count", 32'(chg_cnt), 32'd1);
        mon_en = 1'b0; rst_n = 1'b0; out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        chk("midrst_node_valid", 32'(node_in_valid), 32'd0);
        chk("midrst_hdr_valid", 32'(dummy_ptr_valid), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_halt", 32'(halt), 32'd1);
        tick();

        // Restart after reset: stream begins again at engine 0 node 0 with original data.
        build_model();
        mon_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("restart_valid", 32'(node_in_valid), 32'd1);
        chk("restart_node0", 32'(node_in), 32'(mk_node(0)));
        for (int i = 0; i < 300 && !done; i++) begin
            out_ready = pat[i % 8];
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("run3_done", 32'(done), 32'd1);
        chk("run3_change_count", 32'(chg_cnt), 32'd2);
        chk("run3_stream_drained", 32'(q.size()), 32'd0);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
